// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flow controller beside the ID/EX buffer: load-use bubbles, branch squash, memory freeze.
// Optional stall/flush event counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES    = 1,
    parameter int unsigned MEMREAD_BIT     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic [2:0]  ex_m,
    input  logic        br_taken,
    input  logic        dmem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_we,
    output logic        idex_bubble,
    output logic        exmem_bubble,
`ifdef HAZARD_PERF_CNT_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0] LU_RELOAD = 4'(LU_STALL_CYCLES - 1);
    localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         LU_MULTI  = (LU_STALL_CYCLES > 1);
    localparam bit         FL_MULTI  = (FLUSH_CYCLES > 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_hz;
    logic       w_rt_match;
    logic       w_rs_match;

    // $zero is hardwired, so a load targeting it can never feed a dependent instruction.
    assign w_rs_match = (ex_rt == id_rs);
    assign w_rt_match = id_uses_rt && (ex_rt == id_rt);
    assign w_hz       = ex_m[MEMREAD_BIT] && (ex_rt != 5'd0) && (w_rs_match || w_rt_match);

    assign state = r_state;

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        w_state_next = r_state;
        w_cnt_next   = r_cnt;

        if (!rst_n) begin
            // Reset is visible on the outputs immediately, without waiting for a clock.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            w_state_next = ST_RUN;
            w_cnt_next   = 4'd0;
        end else if (dmem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
        end else if (br_taken) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            if (FL_MULTI) begin
                w_state_next = ST_FLUSH;
                w_cnt_next   = FL_RELOAD;
            end else begin
                w_state_next = ST_RUN;
                w_cnt_next   = 4'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_hz) begin
                        pc_we       = 1'b0;
                        ifid_we     = 1'b0;
                        idex_bubble = 1'b1;
                        if (LU_MULTI) begin
                            w_state_next = ST_LU_STALL;
                            w_cnt_next   = LU_RELOAD;
                        end
                    end
                end
                ST_LU_STALL: begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    if (r_cnt <= 4'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                ST_FLUSH: begin
                    // Squash continues; PC keeps fetching sequentially from the branch target.
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    exmem_bubble = 1'b1;
                    if (r_cnt <= 4'd1) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    // Busy cycles drive every control output low, so they fall out of both events naturally.
    assign w_stall_evt = idex_bubble && !ifid_flush;
    assign w_flush_evt = ifid_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_evt && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default, LU_STALL_CYCLES=3 and FLUSH_CYCLES=2 instances share stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rt;
    logic [2:0] ex_m;
    logic       br_taken;
    logic       dmem_busy;

    logic pc_we_d, ifid_we_d, ifid_flush_d, idex_we_d, idex_bubble_d, exmem_bubble_d;
    logic pc_we_l, ifid_we_l, ifid_flush_l, idex_we_l, idex_bubble_l, exmem_bubble_l;
    logic pc_we_f, ifid_we_f, ifid_flush_f, idex_we_f, idex_bubble_f, exmem_bubble_f;
    logic [1:0] state_d, state_l, state_f;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_d, flush_cnt_d, stall_cnt_l, flush_cnt_l, stall_cnt_f, flush_cnt_f;
`endif

    int errors = 0;
    int checks = 0;

    // Packed view: {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble, state}
    localparam logic [7:0] O_RST = 8'b0010_1100;
    localparam logic [7:0] O_RUN = 8'b1101_0000;
    localparam logic [7:0] O_ST0 = 8'b0001_1000;
    localparam logic [7:0] O_ST1 = 8'b0001_1001;
    localparam logic [7:0] O_BR0 = 8'b1111_1100;
    localparam logic [7:0] O_BR2 = 8'b1111_1110;
    localparam logic [7:0] O_BZ0 = 8'b0000_0000;
    localparam logic [7:0] O_BZ1 = 8'b0000_0001;

    logic [7:0] obs_d, obs_l, obs_f;
    assign obs_d = {pc_we_d, ifid_we_d, ifid_flush_d, idex_we_d, idex_bubble_d, exmem_bubble_d, state_d};
    assign obs_l = {pc_we_l, ifid_we_l, ifid_flush_l, idex_we_l, idex_bubble_l, exmem_bubble_l, state_l};
    assign obs_f = {pc_we_f, ifid_we_f, ifid_flush_f, idex_we_f, idex_bubble_f, exmem_bubble_f, state_f};

    pipeline_hazard_ctrl dut_d (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_m(ex_m), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we_d), .ifid_we(ifid_we_d), .ifid_flush(ifid_flush_d), .idex_we(idex_we_d),
        .idex_bubble(idex_bubble_d), .exmem_bubble(exmem_bubble_d),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt_d), .flush_cnt(flush_cnt_d),
`endif
        .state(state_d)
    );

    pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3)) dut_l (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_m(ex_m), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we_l), .ifid_we(ifid_we_l), .ifid_flush(ifid_flush_l), .idex_we(idex_we_l),
        .idex_bubble(idex_bubble_l), .exmem_bubble(exmem_bubble_l),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt_l), .flush_cnt(flush_cnt_l),
`endif
        .state(state_l)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2)) dut_f (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rt(ex_rt), .ex_m(ex_m), .br_taken(br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we_f), .ifid_we(ifid_we_f), .ifid_flush(ifid_flush_f), .idex_we(idex_we_f),
        .idex_bubble(idex_bubble_f), .exmem_bubble(exmem_bubble_f),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt_f), .flush_cnt(flush_cnt_f),
`endif
        .state(state_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] ed, input logic [7:0] el, input logic [7:0] ef);
        chk({tag, "/dflt"}, {8'h00, obs_d}, {8'h00, ed});
        chk({tag, "/lu3"},  {8'h00, obs_l}, {8'h00, el});
        chk({tag, "/fl2"},  {8'h00, obs_f}, {8'h00, ef});
    endtask

    task automatic drive(input logic [2:0] m, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses, input logic br, input logic busy);
        ex_m       = m;
        ex_rt      = xrt;
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = uses;
        br_taken   = br;
        dmem_busy  = busy;
        #1;
    endtask

    task automatic idle();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        chk3("rst_async", O_RST, O_RST, O_RST);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk3("rst_release", O_RUN, O_RUN, O_RUN);
        tick();

        // Load-use on rs: one bubble by default, three with LU_STALL_CYCLES=3
        drive(3'b010, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        chk3("lu_rs", O_ST0, O_ST0, O_ST0);
        tick();
        idle();
        chk3("lu_cyc2", O_RUN, O_ST1, O_RUN);
        tick();
        idle();
        chk3("lu_cyc3", O_RUN, O_ST1, O_RUN);
        tick();
        idle();
        chk3("lu_done", O_RUN, O_RUN, O_RUN);
        tick();

        drive(3'b010, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk3("zero_reg", O_RUN, O_RUN, O_RUN);
        tick();
        drive(3'b101, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        chk3("no_memread", O_RUN, O_RUN, O_RUN);
        tick();
        drive(3'b010, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0);
        chk3("rt_unused", O_RUN, O_RUN, O_RUN);
        tick();
        drive(3'b010, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        chk3("rt_used", O_ST0, O_ST0, O_ST0);
        tick();

        // Memory wait while the LU3 instance sits in LU_STALL with cnt=2
        for (int i = 0; i < 4; i++) begin
            drive(3'b010, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
            chk3("busy_hold", O_BZ0, O_BZ1, O_BZ0);
            tick();
        end
        idle();
        chk3("busy_rel1", O_RUN, O_ST1, O_RUN);
        tick();
        idle();
        chk3("busy_rel2", O_RUN, O_ST1, O_RUN);
        tick();
        idle();
        chk3("busy_done", O_RUN, O_RUN, O_RUN);
        tick();

        // Branch wins over a simultaneous load-use hazard
        drive(3'b010, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
        chk3("br_over_hz", O_BR0, O_BR0, O_BR0);
        tick();
        idle();
        chk3("flush_cyc", O_RUN, O_RUN, O_BR2);
        tick();
        idle();
        chk3("flush_done", O_RUN, O_RUN, O_RUN);
        tick();

        // Back-to-back branches: second one lands in FLUSH and reloads the count
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk3("br_a", O_BR0, O_BR0, O_BR0);
        tick();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk3("br_reload", O_BR0, O_BR0, O_BR2);
        tick();
        idle();
        chk3("reload_flush", O_RUN, O_RUN, O_BR2);
        tick();
        idle();
        chk3("reload_done", O_RUN, O_RUN, O_RUN);
        tick();

        drive(3'b010, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        chk3("lu_pre_rst", O_ST0, O_ST0, O_ST0);
        tick();
        idle();
        chk3("stall_pre_rst", O_RUN, O_ST1, O_RUN);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_dflt", stall_cnt_d, 16'd3);
        chk("perf_flush_dflt", flush_cnt_d, 16'd3);
        chk("perf_stall_lu3",  stall_cnt_l, 16'd7);
        chk("perf_flush_lu3",  flush_cnt_l, 16'd3);
        chk("perf_stall_fl2",  stall_cnt_f, 16'd3);
        chk("perf_flush_fl2",  flush_cnt_f, 16'd5);
`endif

        // Mid-stall asynchronous reset; the stall must not resume afterwards
        #2;
        rst_n = 1'b0;
        #1;
        chk3("rst_mid_stall", O_RST, O_RST, O_RST);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_rst_stall", stall_cnt_l, 16'd0);
        chk("perf_rst_flush", flush_cnt_f, 16'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk3("rst_mid_release", O_RUN, O_RUN, O_RUN);
        tick();
        idle();
        chk3("no_resume", O_RUN, O_RUN, O_RUN);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
